// File: rtl/norm_controller.sv
// norm_controller: sequences one normalization job over a block of
// accumulator rows. Reads rows from the accumulator buffer, presents each
// normalized row to the output writer with its write address, and holds
// the clamped shift amount for the normalization datapath.
//
// Ports
//   Clk, Rst_n            clock, async active-low reset
//   CfgValid/CfgReady     job request handshake (ready only when idle)
//   CfgShift              signed shift request (+ left, - arithmetic right)
//   CfgRows               rows in the job
//   CfgRdBase/CfgWrBase   start addresses of read and write buffers
//   Abort                 synchronous job cancel
//   RdEn/RdAddr           accumulator-buffer read (data one cycle later)
//   ShiftAmmount          clamped shift, held until the next job
//   NormValid/WrAddr      normalized row toward the writer
//   WrReady               writer accepts the row
//   Busy, Done            job active, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for a job, CfgReady high
// RUN   | issuing reads, one per cycle while the writer keeps up
// DRAIN | all reads issued, waiting for the last row to be accepted
// DONE  | one-cycle completion pulse

module norm_controller #(
  parameter int SA_LENGTH  = 256,
  parameter int IN_WIDTH   = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  CfgValid,
  output logic                  CfgReady,
  input  logic [7:0]            CfgShift,
  input  logic [CNT_WIDTH-1:0]  CfgRows,
  input  logic [ADDR_WIDTH-1:0] CfgRdBase,
  input  logic [ADDR_WIDTH-1:0] CfgWrBase,
  input  logic                  Abort,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] RdAddr,
  output logic [7:0]            ShiftAmmount,
  output logic                  NormValid,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic                  WrReady,
  output logic                  Busy,
  output logic                  Done
);

  // The controller never indexes columns; SA_LENGTH only has to be sane.
  if (SA_LENGTH < 1 || IN_WIDTH < 2 || IN_WIDTH > 128) begin : g_bad_param
    $error("norm_controller: bad parameter (SA_LENGTH >= 1, 2 <= IN_WIDTH <= 128)");
  end

  localparam int MAX_SHIFT = IN_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rows_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [7:0]            shift_q;
  logic                  norm_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic                  accept;
  logic                  adv;
  logic                  rd_en;
  logic                  last_issue;
  logic                  abort_job;
  logic [7:0]            shift_clamped;

  assign accept     = CfgValid && (state_q == IDLE);
  assign adv        = !norm_valid_q || WrReady;
  assign abort_job  = Abort && ((state_q == RUN) || (state_q == DRAIN));
  // In RUN issued < rows always holds: the FSM leaves RUN on the last issue.
  // No read goes out in an abort cycle, so a cancelled job leaves no stray row.
  assign rd_en      = (state_q == RUN) && adv && !Abort;
  assign last_issue = (issued_q == rows_q - CNT_ONE);

  always_comb begin
    int shift_req;
    shift_req     = int'($signed(CfgShift));
    shift_clamped = CfgShift;
    if (shift_req > MAX_SHIFT)
      shift_clamped = 8'(MAX_SHIFT);
    else if (shift_req < -MAX_SHIFT)
      shift_clamped = 8'(-MAX_SHIFT);
  end

  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (CfgRows == '0) ? DONE : RUN;
      RUN:     if (Abort) state_d = IDLE;
               else if (rd_en && last_issue) state_d = DRAIN;
      // Only one row is ever in flight, so the accept seen in DRAIN is the last.
      DRAIN:   if (Abort) state_d = IDLE;
               else if (norm_valid_q && WrReady) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    CfgReady     = (state_q == IDLE);
    Busy         = (state_q != IDLE);
    Done         = (state_q == DONE);
    RdEn         = rd_en;
    RdAddr       = rd_base_q + ADDR_WIDTH'(issued_q);
    NormValid    = norm_valid_q;
    WrAddr       = wr_addr_q;
    ShiftAmmount = shift_q;
  end

  // job datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rows_q       <= '0;
      issued_q     <= '0;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      shift_q      <= '0;
      norm_valid_q <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      if (accept) begin
        rows_q    <= CfgRows;
        issued_q  <= '0;
        rd_base_q <= CfgRdBase;
        wr_base_q <= CfgWrBase;
        shift_q   <= shift_clamped;
      end else if (rd_en) begin
        issued_q <= issued_q + CNT_ONE;
      end

      if (abort_job) begin
        norm_valid_q <= 1'b0;
      end else if (rd_en) begin
        norm_valid_q <= 1'b1;
        wr_addr_q    <= wr_base_q + ADDR_WIDTH'(issued_q);
      end else if (adv) begin
        norm_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_norm_controller.sv
module tb_norm_controller;

  logic       Clk, Rst_n;
  logic       CfgValid, CfgReady;
  logic [7:0] CfgShift;
  logic [15:0] CfgRows;
  logic [9:0] CfgRdBase, CfgWrBase;
  logic       Abort;
  logic       RdEn;
  logic [9:0] RdAddr;
  logic [7:0] ShiftAmmount;
  logic       NormValid;
  logic [9:0] WrAddr;
  logic       WrReady;
  logic       Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;
  int accepts  = 0;
  int dones    = 0;
  int acc0, done0;

  norm_controller dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CfgValid(CfgValid), .CfgReady(CfgReady),
    .CfgShift(CfgShift), .CfgRows(CfgRows),
    .CfgRdBase(CfgRdBase), .CfgWrBase(CfgWrBase),
    .Abort(Abort),
    .RdEn(RdEn), .RdAddr(RdAddr),
    .ShiftAmmount(ShiftAmmount),
    .NormValid(NormValid), .WrAddr(WrAddr), .WrReady(WrReady),
    .Busy(Busy), .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (Rst_n && NormValid && WrReady) accepts++;
    if (Rst_n && Done) dones++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_ready"}, 32'(CfgReady), 32'd1);
    chk({tag, "_busy"},  32'(Busy),     32'd0);
    chk({tag, "_nv"},    32'(NormValid), 32'd0);
    chk({tag, "_rden"},  32'(RdEn),     32'd0);
    chk({tag, "_done"},  32'(Done),     32'd0);
  endtask

  task automatic start_job(input logic [15:0] rows, input logic [9:0] rdb,
                           input logic [9:0] wrb, input logic [7:0] sh);
    CfgRows = rows; CfgRdBase = rdb; CfgWrBase = wrb; CfgShift = sh;
    CfgValid = 1'b1;
    tick();
    CfgValid = 1'b0;
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; CfgValid = 1'b0; CfgShift = '0; CfgRows = '0;
    CfgRdBase = '0; CfgWrBase = '0; Abort = 1'b0; WrReady = 1'b1;

    // reset values
    #12;
    chk("rst_ready", 32'(CfgReady), 32'd1);
    chk("rst_rden",  32'(RdEn), 32'd0);
    chk("rst_rdaddr", 32'(RdAddr), 32'h0);
    chk("rst_nv",    32'(NormValid), 32'd0);
    chk("rst_wraddr", 32'(WrAddr), 32'h0);
    chk("rst_shift", 32'(ShiftAmmount), 32'h0);
    chk("rst_busy",  32'(Busy), 32'd0);
    chk("rst_done",  32'(Done), 32'd0);

    // job 1: accepted on first edge after reset release
    CfgRows = 16'd4; CfgRdBase = 10'h10; CfgWrBase = 10'h20; CfgShift = 8'hF8;
    CfgValid = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    CfgValid = 1'b0;
    #1;
    acc0 = accepts; done0 = dones;
    chk("j1_shift", 32'(ShiftAmmount), 32'h0F8);
    chk("j1_busy",  32'(Busy), 32'd1);
    chk("j1_ready", 32'(CfgReady), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("j1_rden",   32'(RdEn), 32'd1);
      chk("j1_rdaddr", 32'(RdAddr), 32'h10 + 32'(i));
      chk("j1_nv",     32'(NormValid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("j1_wraddr", 32'(WrAddr), 32'h20 + 32'(i - 1));
      tick();
    end
    chk("j1_drain_rden", 32'(RdEn), 32'd0);
    chk("j1_drain_nv",   32'(NormValid), 32'd1);
    chk("j1_drain_wr",   32'(WrAddr), 32'h23);
    chk("j1_drain_done", 32'(Done), 32'd0);
    tick();
    chk("j1_done", 32'(Done), 32'd1);
    chk("j1_done_nv", 32'(NormValid), 32'd0);
    tick();
    chk_idle("j1_idle");
    chk("j1_shift_hold", 32'(ShiftAmmount), 32'h0F8);
    chk("j1_accepts", 32'(accepts - acc0), 32'd4);
    chk("j1_dones",   32'(dones - done0), 32'd1);

    // job 2: stall on row 1
    acc0 = accepts; done0 = dones;
    start_job(16'd3, 10'h40, 10'h80, 8'h00);
    chk("j2_c0_rdaddr", 32'(RdAddr), 32'h40);
    tick();
    chk("j2_c1_rdaddr", 32'(RdAddr), 32'h41);
    chk("j2_c1_wraddr", 32'(WrAddr), 32'h80);
    tick();
    WrReady = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("j2_stall_rden", 32'(RdEn), 32'd0);
      chk("j2_stall_rdaddr", 32'(RdAddr), 32'h42);
      chk("j2_stall_nv", 32'(NormValid), 32'd1);
      chk("j2_stall_wraddr", 32'(WrAddr), 32'h81);
      tick();
    end
    WrReady = 1'b1;
    #1;
    chk("j2_resume_rden", 32'(RdEn), 32'd1);
    chk("j2_resume_rdaddr", 32'(RdAddr), 32'h42);
    chk("j2_resume_wraddr", 32'(WrAddr), 32'h81);
    tick();
    chk("j2_last_wraddr", 32'(WrAddr), 32'h82);
    chk("j2_last_rden", 32'(RdEn), 32'd0);
    tick();
    chk("j2_done", 32'(Done), 32'd1);
    tick();
    chk_idle("j2_idle");
    chk("j2_accepts", 32'(accepts - acc0), 32'd3);
    chk("j2_dones",   32'(dones - done0), 32'd1);

    // shift clamp with zero-row jobs
    acc0 = accepts;
    start_job(16'd0, 10'h0, 10'h0, 8'd100);
    chk("z1_done",  32'(Done), 32'd1);
    chk("z1_rden",  32'(RdEn), 32'd0);
    chk("z1_nv",    32'(NormValid), 32'd0);
    chk("z1_shift", 32'(ShiftAmmount), 32'd31);
    tick();
    chk_idle("z1_idle");
    start_job(16'd0, 10'h0, 10'h0, 8'h80);
    chk("z2_shift", 32'(ShiftAmmount), 32'hE1);
    chk("z2_done",  32'(Done), 32'd1);
    tick();
    chk_idle("z2_idle");
    chk("z_accepts", 32'(accepts - acc0), 32'd0);

    // address wrap
    start_job(16'd2, 10'h3FF, 10'h3FF, 8'h00);
    chk("wrap_rd0", 32'(RdAddr), 32'h3FF);
    tick();
    chk("wrap_rd1", 32'(RdAddr), 32'h000);
    chk("wrap_wr0", 32'(WrAddr), 32'h3FF);
    tick();
    chk("wrap_wr1", 32'(WrAddr), 32'h000);
    tick();
    chk("wrap_done", 32'(Done), 32'd1);
    tick();
    chk_idle("wrap_idle");

    // abort after two of five reads
    done0 = dones;
    start_job(16'd5, 10'h000, 10'h100, 8'h00);
    tick();
    chk("ab_wraddr", 32'(WrAddr), 32'h100);
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk_idle("ab_idle");
    tick();
    chk("ab_no_done", 32'(dones - done0), 32'd0);
    chk_idle("ab_idle2");

    // CfgValid during RUN is ignored
    acc0 = accepts; done0 = dones;
    start_job(16'd3, 10'h020, 10'h030, 8'h00);
    CfgValid = 1'b1; CfgRows = 16'd7; CfgRdBase = 10'h200;
    #1;
    chk("ig_ready", 32'(CfgReady), 32'd0);
    chk("ig_rd0", 32'(RdAddr), 32'h20);
    tick();
    CfgValid = 1'b0;
    chk("ig_rd1", 32'(RdAddr), 32'h21);
    tick();
    chk("ig_rd2", 32'(RdAddr), 32'h22);
    tick();
    chk("ig_wr2", 32'(WrAddr), 32'h32);
    tick();
    chk("ig_done", 32'(Done), 32'd1);
    tick();
    chk_idle("ig_idle");
    tick();
    chk_idle("ig_idle2");
    chk("ig_accepts", 32'(accepts - acc0), 32'd3);
    chk("ig_dones",   32'(dones - done0), 32'd1);

    // reset mid-job
    done0 = dones;
    start_job(16'd5, 10'h050, 10'h060, 8'h05);
    tick();
    tick();
    chk("mr_nv_before", 32'(NormValid), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mr_ready",  32'(CfgReady), 32'd1);
    chk("mr_rden",   32'(RdEn), 32'd0);
    chk("mr_rdaddr", 32'(RdAddr), 32'h0);
    chk("mr_nv",     32'(NormValid), 32'd0);
    chk("mr_wraddr", 32'(WrAddr), 32'h0);
    chk("mr_shift",  32'(ShiftAmmount), 32'h0);
    chk("mr_busy",   32'(Busy), 32'd0);
    chk("mr_done",   32'(Done), 32'd0);
    tick();
    Rst_n = 1'b1;
    tick();
    tick();
    chk_idle("mr_idle");
    chk("mr_no_done", 32'(dones - done0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
